// File: rtl/fpu_pkg.sv
// Shared FPU lane types and constants.
// Used by the float-to-int pipeline and its rounding stage.
package fpu_pkg;

    localparam logic [7:0]  FP_BIAS           = 8'd127;
    localparam logic [7:0]  FTOI_EXP_HALF     = 8'd126;
    localparam logic [7:0]  FTOI_EXP_FRAC_MAX = 8'd150;
    localparam logic [7:0]  FTOI_EXP_OVF      = 8'd158;
    localparam logic [31:0] INT_MIN           = 32'h8000_0000;
    localparam logic [31:0] INT_MAX           = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        ZERO,
        HALF,
        SHR,
        SHL,
        OVF
    } ftoi_class_t;

    typedef struct packed {
        logic        s;
        ftoi_class_t cls;
        logic [4:0]  sh;
        logic [23:0] mant;
    } ftoi_s1_t;

endpackage

// File: rtl/ftoi_round.sv
// Stage-2 magnitude, rounding and sign/overflow resolution.
// Build option FTOI_SATURATE_EN: overflow saturates instead of INT_MIN.
module ftoi_round
    import fpu_pkg::*;
(
    input  ftoi_class_t cls,
    input  logic        s,
    input  logic [23:0] mant,
    input  logic [4:0]  sh,
    output logic [31:0] y
);

    logic [32:0] wide;
    logic [32:0] mag;
    logic        rb;
    logic        unused_msb;

    always_comb begin
        wide = {9'd0, mant};
        rb   = (sh != 5'd0) && mant[sh - 5'd1];
        mag  = '0;
        unique case (cls)
            ZERO:    mag = '0;
            HALF:    mag = 33'd1;
            SHR:     mag = (wide >> sh) + {32'd0, rb};
            SHL:     mag = wide << sh;
            default: mag = '0;
        endcase
        unused_msb = mag[32];
        y = s ? (32'd0 - mag[31:0]) : mag[31:0];
        // Negative overflow, including exact -2^31, always lands on INT_MIN
        if (cls == OVF) begin
`ifdef FTOI_SATURATE_EN
            y = s ? INT_MIN : INT_MAX;
`else
            y = INT_MIN;
`endif
        end
    end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage float-to-int converter, round to nearest, ties away.
// Build option FTOI_SATURATE_EN selects saturating overflow.
module ftoi_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      x,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      y
);

    logic [7:0]       e;
    ftoi_s1_t         s1_d;
    ftoi_s1_t         s1_q;
    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      y_d;

    always_comb begin
        e         = x[30:23];
        s1_d.s    = x[31];
        s1_d.mant = {1'b1, x[22:0]};
        s1_d.sh   = 5'd0;
        s1_d.cls  = ZERO;
        unique case (1'b1)
            (e < FTOI_EXP_HALF): s1_d.cls = ZERO;
            (e == FTOI_EXP_HALF): s1_d.cls = HALF;
            (e > FTOI_EXP_HALF) && (e <= FTOI_EXP_FRAC_MAX): begin
                s1_d.cls = SHR;
                s1_d.sh  = 5'(FTOI_EXP_FRAC_MAX - e);
            end
            (e > FTOI_EXP_FRAC_MAX) && (e < FTOI_EXP_OVF): begin
                s1_d.cls = SHL;
                s1_d.sh  = 5'(e - FTOI_EXP_FRAC_MAX);
            end
            (e >= FTOI_EXP_OVF): s1_d.cls = OVF;
            default: s1_d.cls = ZERO;
        endcase
    end

    ftoi_round u_round (
        .cls  (s1_q.cls),
        .s    (s1_q.s),
        .mant (s1_q.mant),
        .sh   (s1_q.sh),
        .y    (y_d)
    );

    // rst beats flush beats stall; flush only kills valids
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s1_valid  <= 1'b0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            y         <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1_q      <= s1_d;
            s1_valid  <= in_valid;
            s1_tag    <= in_tag;
            out_valid <= s1_valid;
            out_tag   <= s1_tag;
            y         <= y_d;
        end
    end

    always_ff @(posedge clk) begin
        assert (STAGES == 2)
            else $error("ftoi_pipe: STAGES must be 2");
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed self-checking bench for ftoi_pipe.
// Expected overflow values follow FTOI_SATURATE_EN when defined.
module tb_ftoi_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [4:0]  in_tag;
    logic [31:0] x;
    logic        out_valid;
    logic [4:0]  out_tag;
    logic [31:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ftoi_pipe #(.TAG_W(5), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_tag    (in_tag),
        .x         (x),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .y         (y)
    );

`ifdef FTOI_SATURATE_EN
    localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] POS_OVF = 32'h8000_0000;
`endif

    // Issue one op from posedge+1; return valid after 1 and 2 edges
    task automatic run_one(input logic [31:0] xi, input logic [4:0] ti,
                           output logic v1, output logic v2,
                           output logic [31:0] yo, output logic [4:0] to);
        in_valid = 1'b1;
        x        = xi;
        in_tag   = ti;
        @(posedge clk); #1;
        in_valid = 1'b0;
        v1 = out_valid;
        @(posedge clk); #1;
        v2 = out_valid;
        yo = y;
        to = out_tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_tag = '0; x = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || y !== 32'd0 || out_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b y=%h tag=%0d required 0/0/0",
                     out_valid, y, out_tag);
        end
    endtask

    task automatic test_vectors(string name, input logic [31:0] xs [],
                                input logic [31:0] ys []);
        logic v1, v2;
        logic [31:0] yo;
        logic [4:0] to;
        for (int i = 0; i < xs.size(); i++) begin
            run_one(xs[i], 5'(i + 3), v1, v2, yo, to);
            n_checks++;
            if (v1 !== 1'b0 || v2 !== 1'b1) begin
                n_fail++;
                $display("FAIL %s[%0d] latency: valid@1=%b valid@2=%b required 0,1",
                         name, i, v1, v2);
            end
            n_checks++;
            if (yo !== ys[i]) begin
                n_fail++;
                $display("FAIL %s[%0d] x=%h: y=%h required %h",
                         name, i, xs[i], yo, ys[i]);
            end
            n_checks++;
            if (to !== 5'(i + 3)) begin
                n_fail++;
                $display("FAIL %s[%0d] tag: %0d required %0d",
                         name, i, to, i + 3);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] xs [] = '{32'h3FC0_0000, 32'hC020_0000, 32'h3EFA_E148,
                               32'h3F00_0000, 32'h0000_0001, 32'hBECC_CCCD,
                               32'hBF00_0000, 32'h4B00_0001};
        logic [31:0] ys [] = '{32'd2, 32'hFFFF_FFFD, 32'd0,
                               32'd1, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'h0080_0001};
        test_vectors("round", xs, ys);
    endtask

    task automatic test_range();
        logic [31:0] xs [] = '{32'h4EFF_FFFF, 32'hCF00_0000, 32'h4F00_0000,
                               32'h7FC0_0000, 32'hFF80_0000};
        logic [31:0] ys [] = '{32'h7FFF_FF80, 32'h8000_0000, POS_OVF,
                               POS_OVF, 32'h8000_0000};
        test_vectors("range", xs, ys);
    endtask

    task automatic test_back_to_back();
        logic [31:0] tab [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                                 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000,
                                 32'h40E0_0000, 32'h4100_0000};
        int nxt = 0;
        int got = 0;
        logic was_stall;
        logic pv;
        logic [31:0] py;
        logic [4:0] pt;
        pv = out_valid; py = y; pt = out_tag;
        for (int c = 0; c < 20; c++) begin
            stall    = (c >= 5 && c < 8);
            in_valid = (nxt < 8);
            x        = tab[nxt % 8];
            in_tag   = 5'(nxt);
            @(posedge clk);
            was_stall = stall;
            if (!was_stall && in_valid) nxt++;
            #1;
            if (was_stall) begin
                n_checks++;
                if (out_valid !== pv || y !== py || out_tag !== pt) begin
                    n_fail++;
                    $display("FAIL stall_hold c=%0d: v=%b y=%h tag=%0d required %b %h %0d",
                             c, out_valid, y, out_tag, pv, py, pt);
                end
            end else if (out_valid) begin
                n_checks++;
                if (out_tag !== 5'(got) || y !== 32'(got + 1)) begin
                    n_fail++;
                    $display("FAIL stream c=%0d: tag=%0d y=%h required %0d %h",
                             c, out_tag, y, got, got + 1);
                end
                got++;
            end
            pv = out_valid; py = y; pt = out_tag;
        end
        stall = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (got !== 8) begin
            n_fail++;
            $display("FAIL stream_count: %0d outputs required 8", got);
        end
    endtask

    task automatic test_flush_stall();
        in_valid = 1'b1; x = 32'h3F80_0000; in_tag = 5'd1;
        @(posedge clk); #1;
        x = 32'h4000_0000; in_tag = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd1) begin
            n_fail++;
            $display("FAIL flush_pre: v=%b tag=%0d required 1 1", out_valid, out_tag);
        end
        flush = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; stall = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill: v=%b required 0", out_valid);
        end
        in_valid = 1'b1; x = 32'h4040_0000; in_tag = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ghost: v=%b tag=%0d required 0", out_valid, out_tag);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd3 || y !== 32'd3) begin
            n_fail++;
            $display("FAIL flush_next: v=%b tag=%0d y=%h required 1 3 3",
                     out_valid, out_tag, y);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_tail: v=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; x = 32'h40A0_0000; in_tag = 5'd9;
        @(posedge clk); #1;
        x = 32'h40C0_0000; in_tag = 5'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (out_valid !== 1'b0 || y !== 32'd0 || out_tag !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: v=%b y=%h tag=%0d required 0 0 0",
                         k, out_valid, y, out_tag);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_range();
        test_back_to_back();
        test_flush_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Pipelined float-to-int converter in the VLIW FPU lane. It sits directly downstream of the two-stage floor unit.
- Consumes IEEE-754 single results from floor (or raw register operands) and produces signed 32-bit integers for the integer register file.
- Rounding is round-to-nearest, ties away from zero. floor followed by ftoi_pipe therefore yields an exact floor-to-int.
- Two register stages, tagged valid pipeline, with core stall and flush.

Parameters:
TAG_W, 5, width of destination-register tag carried alongside data
STAGES, 2, pipeline depth; fixed at 2, present for documentation and assertion only

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
stall  in  1  core stall; freezes every pipeline register and output
flush  in  1  kill all in-flight ops (mispredict)
in_valid  in  1  x/in_tag valid this cycle
in_tag  in  TAG_W  destination register id
x  in  32  IEEE-754 single operand
out_valid  out  1  y/out_tag valid
out_tag  out  TAG_W  tag of completing op
y  out  32  signed two's-complement result

Behaviour:
- Reset (rst=1 at posedge): s1_valid, out_valid cleared; y, out_tag, all stage regs forced to 0. Reset mid-flight discards all ops, with no partial output.
- Latency: exactly 2 unstalled cycles, in_valid at edge N gives out_valid at edge N+2. Throughput is 1 op/cycle; no internal backpressure.
- stall=1: every register, including outputs, holds. in_valid is ignored (the core re-presents the op).
- flush=1: s1_valid and out_valid cleared at the edge. Data regs may update. flush has priority over stall; rst has priority over both.
- Stage 1 (combinational, registered into s1):
  - unpack s, e, m; mant = {1, m}
  - classify: ZERO if e<126; HALF if e==126; SHR if 127<=e<=150; SHL if 151<=e<=157; OVF if e>=158
  - register s, class, shift amount (150-e for SHR, e-150 for SHL, 5 bits), mant, tag
- Stage 2 magnitude (33-bit intermediate):
  - ZERO → 0. Covers denormals and ±0.
  - HALF → 1.
  - SHR → (mant>>sh) + mant[sh-1]. For sh=0 the round bit is 0. Max result 2^24, no overflow.
  - SHL → mant<<sh, exact, < 2^31.
- Stage 2 sign/overflow:
  - Output is y = s ? -mag : mag.
  - Exception: s=1 and x==0xCF000000 (e=158, m=0) → y=0x80000000, not overflow.
  - Other OVF, including Inf/NaN: see Optional Feature.
- -0.4 → 0, never 0x80000000 or negative zero artifacts.

Optional Feature:
FTOI_SATURATE_EN
- Defined: OVF saturates. y=0x7FFFFFFF if s=0, 0x80000000 if s=1. NaN saturates by its sign bit.
- Undefined: every OVF returns 0x80000000 (integer-indefinite), regardless of sign.
- The -2^31 exact case is identical in both builds.

Decomposition:
- Package fpu_pkg holds:
  - FP_BIAS=127, FTOI_EXP_HALF=126, FTOI_EXP_FRAC_MAX=150, FTOI_EXP_OVF=158
  - INT_MIN=32'h80000000, INT_MAX=32'h7FFFFFFF
  - enum ftoi_class_t {ZERO, HALF, SHR, SHL, OVF}
- One sub-module, ftoi_round: purely combinational stage-2 logic, taking class/s/mant/sh to y. ftoi_pipe owns all registers, valid/tag shift, stall and flush.

Test Plan:
- Rounding: 0x3FC00000 (1.5) → 2; 0xC0200000 (-2.5) → 0xFFFFFFFD (-3); 0x3EFAE148 (0.49) → 0; 0x3F000000 (0.5) → 1; 0x00000001 → 0; each with out_valid exactly 2 cycles after in_valid.
- Range edges: 0x4EFFFFFF → 0x7FFFFF80; 0xCF000000 → 0x80000000 in both builds.
- Overflow: 0x4F000000 and 0x7FC00000 (NaN) → 0x7FFFFFFF with FTOI_SATURATE_EN, 0x80000000 without; 0xFF800000 → 0x80000000 in both builds.
- Stream plus stall: 8 back-to-back ops with tags 0..7, stall high 3 cycles mid-stream → outputs in order, none duplicated or lost, y/out_tag stable during stall.
- Flush and stall together: flush and stall both high with 2 ops in flight → next cycle out_valid=0, ops never appear; the op issued the cycle after completes normally.
- Reset mid-flight: rst high for 1 cycle with 2 ops in flight → y=0, out_tag=0, out_valid=0 for the following 2 cycles.
